// File: rtl/cpu_math_responder.sv
// CPU-bus responder for the hardware multiply/divide register block.
// One unsigned multiply or restoring-divide step is taken per ce strobe.
module cpu_math_responder #(
    parameter logic [15:0] BASE_ADDR = 16'h4200,
    parameter logic [7:0]  INIT_OPND = 8'hFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic [23:0] mem_addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [7:0]  mem_wdata,
    output logic [7:0]  rdata,
    output logic        rdata_hit,
    output logic        busy
);

    localparam logic [15:0] A_WRMPYA = BASE_ADDR + 16'h0002;
    localparam logic [15:0] A_WRMPYB = BASE_ADDR + 16'h0003;
    localparam logic [15:0] A_WRDIVL = BASE_ADDR + 16'h0004;
    localparam logic [15:0] A_WRDIVH = BASE_ADDR + 16'h0005;
    localparam logic [15:0] A_WRDIVB = BASE_ADDR + 16'h0006;
    localparam logic [15:0] A_RDDIVL = BASE_ADDR + 16'h0014;
    localparam logic [15:0] A_RDDIVH = BASE_ADDR + 16'h0015;
    localparam logic [15:0] A_RDMPYL = BASE_ADDR + 16'h0016;
    localparam logic [15:0] A_RDMPYH = BASE_ADDR + 16'h0017;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  wrmpya_q, wrmpya_d;
    logic [7:0]  wrdivl_q, wrdivl_d;
    logic [7:0]  wrdivh_q, wrdivh_d;
    logic [15:0] rddiv_q, rddiv_d;
    logic [15:0] rdmpy_q, rdmpy_d;
    logic [15:0] mcand_q, mcand_d;
    logic [7:0]  mplier_q, mplier_d;
    logic [15:0] dvd_q, dvd_d;
    logic [7:0]  dvs_q, dvs_d;
    logic [15:0] rem_q, rem_d;
    logic [4:0]  cnt_q, cnt_d;

    logic        bank_ok_s;
    logic        wr_en_s;
    logic [16:0] rem_sh_s;
    logic        q_bit_s;
    logic [7:0]  rdata_s;
    logic        rdata_hit_s;

    assign bank_ok_s = (mem_addr[23:22] == 2'b00) || (mem_addr[23:22] == 2'b10);
    assign wr_en_s   = ce & mem_write & bank_ok_s;

    // Next-state: operand writes, op starts (which pre-empt any step) and one math step per ce.
    always_comb begin
        state_d  = state_q;
        wrmpya_d = wrmpya_q;
        wrdivl_d = wrdivl_q;
        wrdivh_d = wrdivh_q;
        rddiv_d  = rddiv_q;
        rdmpy_d  = rdmpy_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        rem_sh_s = {rem_q, dvd_q[15]};
        q_bit_s  = 1'b0;

        // WRMPYB/WRDIVB are consumed only at start, so they land directly in mplier/dvs.
        if (wr_en_s && (mem_addr[15:0] == A_WRMPYB)) begin
            mcand_d  = {8'h00, wrmpya_q};
            mplier_d = mem_wdata;
            rdmpy_d  = 16'h0000;
            rddiv_d  = {8'h00, mem_wdata};
            cnt_d    = 5'd8;
            state_d  = ST_MUL;
        end else if (wr_en_s && (mem_addr[15:0] == A_WRDIVB)) begin
            dvd_d   = {wrdivh_q, wrdivl_q};
            dvs_d   = mem_wdata;
            rem_d   = 16'h0000;
            cnt_d   = 5'd16;
            state_d = ST_DIV;
        end else if (ce && (state_q != ST_IDLE)) begin
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
                state_d = ST_IDLE;
            end else begin
                state_d = state_q;
            end
            case (state_q)
                ST_MUL: begin
                    if (mplier_q[0]) begin
                        rdmpy_d = rdmpy_q + mcand_q;
                    end else begin
                        rdmpy_d = rdmpy_q;
                    end
                    mcand_d  = {mcand_q[14:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[7:1]};
                end
                ST_DIV: begin
                    if (rem_sh_s >= {9'h000, dvs_q}) begin
                        rem_d   = rem_sh_s[15:0] - {8'h00, dvs_q};
                        q_bit_s = 1'b1;
                    end else begin
                        rem_d   = rem_sh_s[15:0];
                        q_bit_s = 1'b0;
                    end
                    dvd_d   = {dvd_q[14:0], 1'b0};
                    rddiv_d = {rddiv_q[14:0], q_bit_s};
                    rdmpy_d = rem_d;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 5'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        if (wr_en_s) begin
            case (mem_addr[15:0])
                A_WRMPYA: wrmpya_d = mem_wdata;
                A_WRDIVL: wrdivl_d = mem_wdata;
                A_WRDIVH: wrdivh_d = mem_wdata;
                default:  wrmpya_d = wrmpya_q;
            endcase
        end else begin
            wrmpya_d = wrmpya_q;
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            wrmpya_q <= INIT_OPND;
            wrdivl_q <= INIT_OPND;
            wrdivh_q <= INIT_OPND;
            rddiv_q  <= 16'h0000;
            rdmpy_q  <= 16'h0000;
            mcand_q  <= 16'h0000;
            mplier_q <= 8'h00;
            dvd_q    <= 16'h0000;
            dvs_q    <= INIT_OPND;
            rem_q    <= 16'h0000;
            cnt_q    <= 5'd0;
        end else begin
            state_q  <= state_d;
            wrmpya_q <= wrmpya_d;
            wrdivl_q <= wrdivl_d;
            wrdivh_q <= wrdivh_d;
            rddiv_q  <= rddiv_d;
            rdmpy_q  <= rdmpy_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
        end
    end

    // Read-back mux for the result registers; anything else reads as open bus.
    always_comb begin
        rdata_s     = 8'h00;
        rdata_hit_s = 1'b0;
        if (mem_read && bank_ok_s) begin
            rdata_hit_s = 1'b1;
            case (mem_addr[15:0])
                A_RDDIVL: rdata_s = rddiv_q[7:0];
                A_RDDIVH: rdata_s = rddiv_q[15:8];
                A_RDMPYL: rdata_s = rdmpy_q[7:0];
                A_RDMPYH: rdata_s = rdmpy_q[15:8];
                default:  rdata_hit_s = 1'b0;
            endcase
        end else begin
            rdata_hit_s = 1'b0;
        end
    end

    assign rdata     = rdata_s;
    assign rdata_hit = rdata_hit_s;
    assign busy      = (state_q != ST_IDLE);

endmodule
